// File: rtl/p1v_uart_rx_if.sv
// Byte stream from the P30 console receiver: head-of-FIFO data with valid/ready.
// The receiver drives the master side and the consumer drives the slave side.
interface p1v_uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/p1v_uart_rx.sv
// 8N1 receiver for the Propeller TX line: 2-flop synchroniser, mid-bit sampling
// decoder and a first-word-fall-through byte FIFO with sticky error flags.
module p1v_uart_rx #(
  parameter int CLKS_PER_BIT = 1389,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clock_160,
  input  logic                        res,
  input  logic                        rxd,
  p1v_uart_rx_if.master               rx,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        frame_err,
  output logic                        overrun,
  input  logic                        clear_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic [1:0]    r_sync;
  state_t        r_state;
  logic [15:0]   r_cnt;
  logic [7:0]    r_shreg;
  logic [2:0]    r_bitidx;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_count;
  logic          r_frame_err;
  logic          r_overrun;
  logic [7:0]    r_ram [FIFO_DEPTH];

  logic          w_rxd_s;
  logic          w_tick;
  state_t        w_state_next;
  logic [15:0]   w_cnt_next;
  logic [7:0]    w_shreg_next;
  logic [2:0]    w_bitidx_next;
  logic          w_push_req;
  logic          w_ferr_set;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_ovr_set;

  assign w_rxd_s = r_sync[1];
  assign w_tick  = (r_cnt == 16'd0);

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_shreg_next  = r_shreg;
    w_bitidx_next = r_bitidx;
    w_push_req    = 1'b0;
    w_ferr_set    = 1'b0;
    if (r_state != S_IDLE) begin
      w_cnt_next = w_tick ? BIT_M1 : r_cnt - 16'd1;
    end
    case (r_state)
      S_IDLE: begin
        if (!w_rxd_s) begin
          w_cnt_next   = HALF_M1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (!w_rxd_s) begin
            w_state_next  = S_DATA;
            w_bitidx_next = 3'd0;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shreg_next  = {w_rxd_s, r_shreg[7:1]};
          w_bitidx_next = r_bitidx + 3'd1;
          if (r_bitidx == 3'd7) begin
            w_state_next = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (w_rxd_s) begin
            w_push_req   = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_ferr_set   = 1'b1;
            w_state_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (w_rxd_s) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Fullness is judged after a same-cycle pop, so a full FIFO being drained still accepts.
  assign w_full    = (r_count == LW'(FIFO_DEPTH));
  assign w_pop     = rx.rx_valid & rx.rx_ready;
  assign w_push    = w_push_req & (~w_full | w_pop);
  assign w_ovr_set = w_push_req & w_full & ~w_pop;

  always_ff @(posedge clock_160) begin
    if (res) begin
      r_sync      <= 2'b11;
      r_state     <= S_IDLE;
      r_cnt       <= 16'd0;
      r_shreg     <= 8'd0;
      r_bitidx    <= 3'd0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], rxd};
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_shreg  <= w_shreg_next;
      r_bitidx <= w_bitidx_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + LW'(w_push) - LW'(w_pop);
      // A new error event wins over a clear in the same cycle.
      if (w_ferr_set) begin
        r_frame_err <= 1'b1;
      end else if (clear_err) begin
        r_frame_err <= 1'b0;
      end
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (clear_err) begin
        r_overrun <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock_160) begin
    if (w_push && !res) begin
      r_ram[r_wr_ptr] <= r_shreg;
    end
  end

  assign rx.rx_valid = (r_count != '0);
  assign rx.rx_data  = rx.rx_valid ? r_ram[r_rd_ptr] : 8'h00;
  assign level       = r_count;
  assign frame_err   = r_frame_err;
  assign overrun     = r_overrun;

endmodule
